bsg_cycle_counter_bank_ctrl: RTL and testbench

- Controller for a bank of els_p cycle/event counters of width_p bits, each the same free-running increment datapath as the team's cycle counter.
- Accepts start/stop/clear/read commands over a valid/ready port and returns read snapshots over a valid/yumi response port.
- Sits beside the performance-monitoring logic; software-facing CSR logic drives the command port.

---
 rtl/bsg_cycle_counter_bank_ctrl_if.sv | 29 ++
 rtl/bsg_cycle_counter_bank_ctrl.sv | 153 +++++++++++++++
 tb/tb_bsg_cycle_counter_bank_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/bsg_cycle_counter_bank_ctrl_if.sv
// Command/response bus of the counter-bank controller.
// Signal suffixes are taken from the controller's point of view.
interface bsg_cycle_counter_bank_ctrl_if #(
  parameter int width_p = 64,
  parameter int els_p   = 4
);
  localparam int lg_els_lp = (els_p > 2) ? $clog2(els_p) : 1;

  logic                 cmd_v_i;
  logic [1:0]           cmd_op_i;
  logic [lg_els_lp-1:0] cmd_id_i;
  logic                 cmd_ready_o;

  logic                 resp_v_o;
  logic [width_p-1:0]   resp_data_o;
  logic [lg_els_lp-1:0] resp_id_o;
  logic                 resp_overflow_o;
  logic                 resp_yumi_i;

  modport master (
    output cmd_v_i, cmd_op_i, cmd_id_i, resp_yumi_i,
    input  cmd_ready_o, resp_v_o, resp_data_o, resp_id_o, resp_overflow_o
  );

  modport slave (
    input  cmd_v_i, cmd_op_i, cmd_id_i, resp_yumi_i,
    output cmd_ready_o, resp_v_o, resp_data_o, resp_id_o, resp_overflow_o
  );
endinterface

// File: rtl/bsg_cycle_counter_bank_ctrl.sv
// Bank of free-running event counters with start/stop/clear/read commands
// and a single-entry read-snapshot response held until the consumer yumis.
module bsg_cycle_counter_bank_ctrl #(
  parameter int width_p = 64,
  parameter int els_p   = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [els_p-1:0]                 event_i,
  bsg_cycle_counter_bank_ctrl_if.slave     bus,
  output logic [els_p-1:0]                 enabled_o,
  output logic [els_p-1:0]                 overflow_o
);

  localparam int lg_els_lp = (els_p > 2) ? $clog2(els_p) : 1;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_STOP  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_READ  = 2'd3
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e state_r, state_n;

  logic [width_p-1:0]   ctr_r [els_p];
  logic [width_p-1:0]   ctr_n [els_p];
  logic [els_p-1:0]     enabled_r, enabled_n;
  logic [els_p-1:0]     overflow_r, overflow_n;
  logic [els_p-1:0]     sel;

  logic                 cmd_ready;
  logic                 cmd_fire;
  logic                 read_fire;
  op_e                  op;

  logic [width_p-1:0]   rd_data;
  logic                 rd_overflow;

  logic [width_p-1:0]   resp_data_r;
  logic [lg_els_lp-1:0] resp_id_r;
  logic                 resp_overflow_r;

  // Ready is a pure function of state and reset so it never loops back through cmd_v_i.
  assign cmd_ready = reset_n_i && (state_r == IDLE);
  assign cmd_fire  = bus.cmd_v_i && cmd_ready;
  assign op        = op_e'(bus.cmd_op_i);
  assign read_fire = cmd_fire && (op == OP_READ);

  // One-hot decode; an out-of-range id selects nothing.
  always_comb begin
    sel = '0;
    for (int i = 0; i < els_p; i++) begin
      sel[i] = (bus.cmd_id_i == lg_els_lp'(i));
    end
  end

  always_comb begin
    ctr_n      = ctr_r;
    enabled_n  = enabled_r;
    overflow_n = overflow_r;
    for (int i = 0; i < els_p; i++) begin
      if (enabled_r[i] && event_i[i]) begin
        ctr_n[i] = ctr_r[i] + width_p'(1);
        if (&ctr_r[i]) begin
          overflow_n[i] = 1'b1;
        end
      end
      // A command lands after the increment so CLEAR wins over a same-cycle wrap.
      if (cmd_fire && sel[i]) begin
        case (op)
          OP_START: enabled_n[i] = 1'b1;
          OP_STOP:  enabled_n[i] = 1'b0;
          OP_CLEAR: begin
            ctr_n[i]      = '0;
            overflow_n[i] = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < els_p; i++) begin
        ctr_r[i] <= '0;
      end
      enabled_r  <= '0;
      overflow_r <= '0;
    end else begin
      for (int i = 0; i < els_p; i++) begin
        ctr_r[i] <= ctr_n[i];
      end
      enabled_r  <= enabled_n;
      overflow_r <= overflow_n;
    end
  end

  always_comb begin
    rd_data     = '0;
    rd_overflow = 1'b0;
    for (int i = 0; i < els_p; i++) begin
      if (sel[i]) begin
        rd_data     = ctr_r[i];
        rd_overflow = overflow_r[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      resp_data_r     <= '0;
      resp_id_r       <= '0;
      resp_overflow_r <= 1'b0;
    end else if (read_fire) begin
      resp_data_r     <= rd_data;
      resp_id_r       <= bus.cmd_id_i;
      resp_overflow_r <= rd_overflow;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    if (read_fire)       state_n = RESP;
      RESP:    if (bus.resp_yumi_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.cmd_ready_o     = cmd_ready;
  assign bus.resp_v_o        = (state_r == RESP);
  assign bus.resp_data_o     = resp_data_r;
  assign bus.resp_id_o       = resp_id_r;
  assign bus.resp_overflow_o = resp_overflow_r;
  assign enabled_o           = enabled_r;
  assign overflow_o          = overflow_r;

endmodule

// File: tb/tb_bsg_cycle_counter_bank_ctrl.sv
// Directed bench: dut_a (8-bit, 4 counters) covers timing, backpressure, clear and
// wrap; dut_b (8-bit, 3 counters) covers out-of-range ids and mid-response reset.
module tb_bsg_cycle_counter_bank_ctrl;

  localparam int W = 8;

  logic       clk;
  logic       rst_a_n, rst_b_n;
  logic [3:0] ev_a, en_a, ov_a;
  logic [2:0] ev_b, en_b, ov_b;

  int cmp_count  = 0;
  int fail_count = 0;

  bsg_cycle_counter_bank_ctrl_if #(.width_p(W), .els_p(4)) bus_a ();
  bsg_cycle_counter_bank_ctrl_if #(.width_p(W), .els_p(3)) bus_b ();

  bsg_cycle_counter_bank_ctrl #(.width_p(W), .els_p(4)) dut_a (
    .clk_i(clk), .reset_n_i(rst_a_n), .event_i(ev_a), .bus(bus_a.slave),
    .enabled_o(en_a), .overflow_o(ov_a)
  );

  bsg_cycle_counter_bank_ctrl #(.width_p(W), .els_p(3)) dut_b (
    .clk_i(clk), .reset_n_i(rst_b_n), .event_i(ev_b), .bus(bus_b.slave),
    .enabled_o(en_b), .overflow_o(ov_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [1:0] id);
    bus_a.cmd_v_i  = v;
    bus_a.cmd_op_i = op;
    bus_a.cmd_id_i = id;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    ev_a = 4'hF;
    ev_b = 3'h7;
    applyStimulus(1'b1, 2'd0, 2'd0);
    bus_a.resp_yumi_i = 1'b0;
    bus_b.cmd_v_i     = 1'b1;
    bus_b.cmd_op_i    = 2'd0;
    bus_b.cmd_id_i    = 2'd0;
    bus_b.resp_yumi_i = 1'b0;

    // reset with a command pending
    tick();
    tick();
    checkOutput("rst_ready",     64'(bus_a.cmd_ready_o), 64'd0);
    checkOutput("rst_resp_v",    64'(bus_a.resp_v_o), 64'd0);
    checkOutput("rst_resp_data", 64'(bus_a.resp_data_o), 64'd0);
    checkOutput("rst_resp_id",   64'(bus_a.resp_id_o), 64'd0);
    checkOutput("rst_resp_ovf",  64'(bus_a.resp_overflow_o), 64'd0);
    checkOutput("rst_en",        64'(en_a), 64'd0);
    checkOutput("rst_ov",        64'(ov_a), 64'd0);
    checkOutput("rst_en_b",      64'(en_b), 64'd0);

    applyStimulus(1'b0, 2'd0, 2'd0);
    bus_b.cmd_v_i = 1'b0;
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    #1;
    checkOutput("rel_ready", 64'(bus_a.cmd_ready_o), 64'd1);
    repeat (3) tick();
    checkOutput("idle_en", 64'(en_a), 64'd0);
    applyStimulus(1'b1, 2'd3, 2'd0);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0);
    checkOutput("idle_read_v",    64'(bus_a.resp_v_o), 64'd1);
    checkOutput("idle_read_data", 64'(bus_a.resp_data_o), 64'd0);
    checkOutput("idle_ready",     64'(bus_a.cmd_ready_o), 64'd0);
    bus_a.resp_yumi_i = 1'b1;
    tick();
    bus_a.resp_yumi_i = 1'b0;
    checkOutput("yumi_v",     64'(bus_a.resp_v_o), 64'd0);
    checkOutput("yumi_ready", 64'(bus_a.cmd_ready_o), 64'd1);

    // run/stop timing on counter 0: five qualified cycles
    applyStimulus(1'b1, 2'd0, 2'd0);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0);
    checkOutput("start_en0", 64'(en_a[0]), 64'd1);
    repeat (4) tick();
    applyStimulus(1'b1, 2'd1, 2'd0);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0);
    checkOutput("stop_en0", 64'(en_a[0]), 64'd0);
    repeat (2) tick();
    applyStimulus(1'b1, 2'd3, 2'd0);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0);
    checkOutput("run_data", 64'(bus_a.resp_data_o), 64'd5);
    checkOutput("run_id",   64'(bus_a.resp_id_o), 64'd0);
    checkOutput("run_ovf",  64'(bus_a.resp_overflow_o), 64'd0);
    bus_a.resp_yumi_i = 1'b1;
    tick();
    bus_a.resp_yumi_i = 1'b0;

    // backpressure on counter 1 with a STOP blocked during RESP
    applyStimulus(1'b1, 2'd0, 2'd1);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0);
    repeat (2) tick();
    applyStimulus(1'b1, 2'd3, 2'd1);
    tick();
    applyStimulus(1'b1, 2'd1, 2'd1);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("bp_v%0d", k),     64'(bus_a.resp_v_o), 64'd1);
      checkOutput($sformatf("bp_data%0d", k),  64'(bus_a.resp_data_o), 64'd2);
      checkOutput($sformatf("bp_ready%0d", k), 64'(bus_a.cmd_ready_o), 64'd0);
      tick();
    end
    checkOutput("bp_id", 64'(bus_a.resp_id_o), 64'd1);
    applyStimulus(1'b0, 2'd0, 2'd0);
    bus_a.resp_yumi_i = 1'b1;
    tick();
    bus_a.resp_yumi_i = 1'b0;
    checkOutput("bp_after_v",     64'(bus_a.resp_v_o), 64'd0);
    checkOutput("bp_after_ready", 64'(bus_a.cmd_ready_o), 64'd1);
    checkOutput("bp_blocked_stop", 64'(en_a[1]), 64'd1);

    // CLEAR on a running counter 2
    applyStimulus(1'b1, 2'd0, 2'd2);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0);
    repeat (3) tick();
    applyStimulus(1'b1, 2'd2, 2'd2);
    tick();
    applyStimulus(1'b1, 2'd3, 2'd2);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0);
    checkOutput("clr_read0", 64'(bus_a.resp_data_o), 64'd0);
    checkOutput("clr_en2",   64'(en_a[2]), 64'd1);
    bus_a.resp_yumi_i = 1'b1;
    tick();
    bus_a.resp_yumi_i = 1'b0;
    applyStimulus(1'b1, 2'd3, 2'd2);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0);
    checkOutput("clr_read2", 64'(bus_a.resp_data_o), 64'd2);
    bus_a.resp_yumi_i = 1'b1;
    tick();
    bus_a.resp_yumi_i = 1'b0;

    // wrap on counter 3 after 257 events
    applyStimulus(1'b1, 2'd0, 2'd3);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0);
    repeat (255) tick();
    checkOutput("pre_wrap_ov3", 64'(ov_a[3]), 64'd0);
    tick();
    applyStimulus(1'b1, 2'd1, 2'd3);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0);
    checkOutput("wrap_ov3", 64'(ov_a[3]), 64'd1);
    checkOutput("wrap_en3", 64'(en_a[3]), 64'd0);
    applyStimulus(1'b1, 2'd3, 2'd3);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0);
    checkOutput("wrap_data", 64'(bus_a.resp_data_o), 64'd1);
    checkOutput("wrap_id",   64'(bus_a.resp_id_o), 64'd3);
    checkOutput("wrap_ovf",  64'(bus_a.resp_overflow_o), 64'd1);
    bus_a.resp_yumi_i = 1'b1;
    tick();
    bus_a.resp_yumi_i = 1'b0;
    applyStimulus(1'b1, 2'd2, 2'd3);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0);
    checkOutput("clr_ov3", 64'(ov_a[3]), 64'd0);

    // out-of-range id and mid-response reset on dut_b
    bus_b.cmd_v_i  = 1'b1;
    bus_b.cmd_op_i = 2'd0;
    bus_b.cmd_id_i = 2'd3;
    tick();
    checkOutput("oor_start_en", 64'(en_b), 64'd0);
    bus_b.cmd_op_i = 2'd3;
    tick();
    bus_b.cmd_v_i = 1'b0;
    checkOutput("oor_v",    64'(bus_b.resp_v_o), 64'd1);
    checkOutput("oor_data", 64'(bus_b.resp_data_o), 64'd0);
    checkOutput("oor_id",   64'(bus_b.resp_id_o), 64'd3);
    checkOutput("oor_ovf",  64'(bus_b.resp_overflow_o), 64'd0);
    rst_b_n = 1'b0;
    tick();
    checkOutput("mid_rst_v",     64'(bus_b.resp_v_o), 64'd0);
    checkOutput("mid_rst_id",    64'(bus_b.resp_id_o), 64'd0);
    checkOutput("mid_rst_ready", 64'(bus_b.cmd_ready_o), 64'd0);
    rst_b_n = 1'b1;
    #1;
    checkOutput("mid_rel_ready", 64'(bus_b.cmd_ready_o), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
